// File: rtl/mtm_alu_pkg.sv
// Shared constants and types for the ALU serial input path.
//  - opcode encodings accepted by the ALU core
//  - packet type bit values carried in the second bit of every frame
//  - bit positions inside the 3-bit error flag vector
//  - CRC4 generator (x^4 + x + 1, leading term implicit)
//  - receiver FSM state encoding
package mtm_alu_pkg;

    localparam int DATA_PKTS_DEF = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CMD  = 1'b1;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam logic [3:0] CRC4_POLY  = 4'b0011;
    localparam int         CRC4_MSG_W = 68;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TYPE   = 3'd1,
        ST_BITS   = 3'd2,
        ST_STOP   = 3'd3,
        ST_REPORT = 3'd4,
        ST_RESYNC = 3'd5
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC4 over a 68-bit message, MSB first, register initialised
// to zero, generator x^4 + x + 1.
// Ports:
//  data_i  in  68  message bits, data_i[67] is processed first
//  crc_o   out 4   resulting CRC remainder
module mtm_alu_crc4
    import mtm_alu_pkg::*;
(
    input  logic [CRC4_MSG_W-1:0] data_i,
    output logic [3:0]            crc_o
);

    logic [3:0] crc_v;
    logic       fb_v;

    // Bit-serial LFSR unrolled over the whole message.
    always_comb begin
        crc_v = 4'b0000;
        fb_v  = 1'b0;
        for (int i = CRC4_MSG_W - 1; i >= 0; i--) begin
            fb_v  = crc_v[3] ^ data_i[i];
            crc_v = {crc_v[2:0], 1'b0} ^ (fb_v ? CRC4_POLY : 4'b0000);
        end
    end

    assign crc_o = crc_v;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial receiver in front of the ALU core. Assembles 8 DATA packets
// (B bytes MSB first, then A bytes) and one CMD packet {0,OP,CRC}, checks
// framing, packet count, CRC and opcode, then presents the operands with a
// one-cycle strobe or reports the rejection with a one-cycle error strobe.
// Ports:
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   synchronous reset, active high
//  sin        in   1   serial input, idle high, one bit per clock
//  A, B       out  32  operands, held until the next good transaction
//  OP         out  3   opcode, held until the next good transaction
//  out_valid  out  1   one-cycle pulse for an accepted transaction
//  err_valid  out  1   one-cycle pulse for a rejected transaction
//  err_flags  out  3   {ERR_DATA, ERR_CRC, ERR_OP}, held until next err_valid
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int DATA_PKTS = DATA_PKTS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  OP,
    output logic        out_valid,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    localparam logic [3:0] PKTS_FULL = 4'(DATA_PKTS);

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte_sr_q, byte_sr_d;
    logic        type_q, type_d;
    logic [63:0] opnd_sr_q, opnd_sr_d;   // {B, A} once all DATA bytes are in
    logic [6:0]  cmd_q, cmd_d;           // {OP, CRC}; CMD bit 7 carries nothing
    logic        err_data_q, err_data_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        out_valid_q, out_valid_d;
    logic        err_valid_q, err_valid_d;
    logic [2:0]  err_flags_q, err_flags_d;

    logic [3:0]  crc_calc;
    logic        crc_ok;
    logic        op_ok;

    mtm_alu_crc4 u_crc (
        .data_i ({opnd_sr_q, 1'b1, cmd_q[6:4]}),
        .crc_o  (crc_calc)
    );

    assign crc_ok = (crc_calc == cmd_q[3:0]);
    assign op_ok  = op_is_legal(cmd_q[6:4]);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        byte_sr_d   = byte_sr_q;
        type_d      = type_q;
        opnd_sr_d   = opnd_sr_q;
        cmd_d       = cmd_q;
        err_data_d  = err_data_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = 1'b0;
        err_valid_d = 1'b0;
        err_flags_d = err_flags_q;

        case (state_q)
            ST_IDLE: begin
                if (!sin) state_d = ST_TYPE;
            end
            ST_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = ST_BITS;
            end
            ST_BITS: begin
                byte_sr_d = {byte_sr_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (!sin) begin
                    err_data_d = 1'b1;
                    state_d    = ST_REPORT;
                end else if (type_q == PKT_DATA) begin
                    if (byte_cnt_q == PKTS_FULL) begin
                        // Surplus DATA packet: abort rather than let the counter wrap.
                        err_data_d = 1'b1;
                        state_d    = ST_REPORT;
                    end else begin
                        opnd_sr_d  = {opnd_sr_q[55:0], byte_sr_q};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    if (byte_cnt_q != PKTS_FULL) begin
                        err_data_d = 1'b1;
                    end else begin
                        cmd_d      = byte_sr_q[6:0];
                        err_data_d = 1'b0;
                    end
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                byte_cnt_d  = 4'd0;
                err_flags_d = 3'b000;
                if (err_data_q) begin
                    err_flags_d[ERR_DATA] = 1'b1;
                end else if (!crc_ok) begin
                    err_flags_d[ERR_CRC] = 1'b1;
                end else if (!op_ok) begin
                    err_flags_d[ERR_OP] = 1'b1;
                end
                if (err_data_q || !crc_ok || !op_ok) begin
                    err_valid_d = 1'b1;
                    state_d     = ST_RESYNC;
                end else begin
                    // Keep the previously reported flags on success.
                    err_flags_d = err_flags_q;
                    out_valid_d = 1'b1;
                    b_d         = opnd_sr_q[63:32];
                    a_d         = opnd_sr_q[31:0];
                    op_d        = cmd_q[6:4];
                    state_d     = ST_IDLE;
                end
            end
            ST_RESYNC: begin
                // A rejected frame may leave us mid-stream; wait for idle-high
                // so a payload 0 is not mistaken for a start bit.
                if (sin) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            byte_sr_q   <= '0;
            type_q      <= 1'b0;
            opnd_sr_q   <= '0;
            cmd_q       <= '0;
            err_data_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_sr_q   <= byte_sr_d;
            type_q      <= type_d;
            opnd_sr_q   <= opnd_sr_d;
            cmd_q       <= cmd_d;
            err_data_q  <= err_data_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            err_valid_q <= err_valid_d;
            err_flags_q <= err_flags_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign OP        = op_q;
    assign out_valid = out_valid_q;
    assign err_valid = err_valid_q;
    assign err_flags = err_flags_q;

endmodule
